// File: rtl/pic_pkg.sv
// Shared constants for the PIC-style register file datapath: file address
// width, the INDF alias address and default geometry.
package pic_pkg;

  localparam int          FILE_ADDR_W      = 5;
  localparam int          DATA_W_DEFAULT   = 8;
  localparam logic [4:0]  INDF_ADDR        = 5'h00;
  localparam logic [4:0]  GPR_BASE_DEFAULT = 5'h08;

  typedef logic [FILE_ADDR_W-1:0] file_addr_t;

endpackage

// File: rtl/fsr_addr_resolve.sv
// Indirection and range decode: resolves INDF through the FSR pointer and
// classifies the effective address for the general-purpose file.
module fsr_addr_resolve
  import pic_pkg::*;
#(
  parameter logic [4:0] GPR_BASE = GPR_BASE_DEFAULT
) (
  input  logic [FILE_ADDR_W-1:0] addr,
  input  logic [FILE_ADDR_W-1:0] fsr_in,
  output logic [FILE_ADDR_W-1:0] eff,
  output logic                   hit,
  output logic                   is_indf_self
);

  assign eff          = (addr == INDF_ADDR) ? fsr_in : addr;
  assign hit          = (eff >= GPR_BASE);
  // A direct address is never zero, so eff == INDF only when INDF points at itself.
  assign is_indf_self = (eff == INDF_ADDR);

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file with INDF/FSR indirection and a tri-state read bus.
// Optional macro GPR_FILE_CLEAR_ON_RESET_EN clears every GPR on reset.
module gpr_file
  import pic_pkg::*;
#(
  parameter int         DATA_W   = DATA_W_DEFAULT,
  parameter logic [4:0] GPR_BASE = GPR_BASE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [4:0]        addr,
  input  logic [4:0]        fsr_in,
  input  logic              out_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              hit,
  output logic              ind_err
);

  localparam int NUM_GPR = 32 - int'(GPR_BASE);

  logic [FILE_ADDR_W-1:0] eff;
  logic                   is_indf_self;
  logic [FILE_ADDR_W-1:0] gpr_idx;
  logic [NUM_GPR-1:0]     wr_sel;
  logic [DATA_W-1:0]      file_reg [NUM_GPR];
  logic                   ind_err_reg;

  fsr_addr_resolve #(
    .GPR_BASE     (GPR_BASE)
  ) u_resolve (
    .addr         (addr),
    .fsr_in       (fsr_in),
    .eff          (eff),
    .hit          (hit),
    .is_indf_self (is_indf_self)
  );

  assign gpr_idx = eff - GPR_BASE;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : g_wr_sel
      localparam logic [4:0] ENTRY_ADDR = GPR_BASE + 5'(gi);
      assign wr_sel[gi] = write_en && hit && (eff == ENTRY_ADDR);
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_GPR; i++) begin
`ifdef GPR_FILE_CLEAR_ON_RESET_EN
      if (!reset_n)
        file_reg[i] <= '0;
      else if (wr_sel[i])
        file_reg[i] <= data_in;
`else
      // Contents survive reset; reset only blocks the write in that cycle.
      if (reset_n && wr_sel[i])
        file_reg[i] <= data_in;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      ind_err_reg <= 1'b0;
    else if ((out_en || write_en) && is_indf_self)
      ind_err_reg <= 1'b1;
  end

  assign ind_err = ind_err_reg;

  // Self-indirect reads return zero; SFR addresses belong to other blocks, so release the bus.
  assign data_out = (out_en && hit)          ? file_reg[gpr_idx] :
                    (out_en && is_indf_self) ? '0                :
                                               'z;

endmodule
